// File: rtl/btb_assoc_if.sv
// Fetch/update bus of the set-associative BTB: lookup PC, execute-stage update
// and flush requests toward the BTB, per-slot predictions back to the frontend.
interface btb_assoc_if #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned INSTR_PER_FETCH = 2
);
  logic                              flush_bp_i;
  logic                              debug_mode_i;
  logic [VLEN-1:0]                   vpc_i;
  logic                              update_valid_i;
  logic [VLEN-1:0]                   update_pc_i;
  logic [VLEN-1:0]                   update_target_i;
  logic [INSTR_PER_FETCH-1:0]        pred_valid_o;
  logic [INSTR_PER_FETCH*VLEN-1:0]   pred_target_o;
  logic                              flush_busy_o;

  modport master (
    output flush_bp_i, debug_mode_i, vpc_i, update_valid_i, update_pc_i, update_target_i,
    input  pred_valid_o, pred_target_o, flush_busy_o
  );

  modport slave (
    input  flush_bp_i, debug_mode_i, vpc_i, update_valid_i, update_pc_i, update_target_i,
    output pred_valid_o, pred_target_o, flush_busy_o
  );
endinterface

// File: rtl/btb_assoc.sv
// Tagged set-associative branch target buffer with partial tags, round-robin
// replacement and a row-by-row flush sweep.
module btb_assoc #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned RVC             = 1,
  parameter int unsigned NR_ROWS         = 16,
  parameter int unsigned NR_WAYS         = 2,
  parameter int unsigned TAG_BITS        = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  btb_assoc_if.slave  bus
);

  localparam int unsigned OFFSET = (RVC != 0) ? 1 : 2;
  localparam int unsigned RA     = $clog2(INSTR_PER_FETCH);
  localparam int unsigned RB     = $clog2(NR_ROWS);
  localparam int unsigned SLOT_W = (INSTR_PER_FETCH > 1) ? RA : 1;
  localparam int unsigned WAY_W  = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_e;

  function automatic logic [SLOT_W-1:0] slot_of(input logic [VLEN-1:0] pc);
    return (RVC != 0) ? SLOT_W'((pc >> OFFSET) & VLEN'(INSTR_PER_FETCH - 1)) : {SLOT_W{1'b0}};
  endfunction

  function automatic logic [RB-1:0] row_of(input logic [VLEN-1:0] pc);
    return RB'(pc >> (RA + OFFSET));
  endfunction

  function automatic logic [TAG_BITS-1:0] tag_of(input logic [VLEN-1:0] pc);
    return TAG_BITS'(pc >> (RA + RB + OFFSET));
  endfunction

  // With a single way there is no pointer to advance; it stays at zero.
  function automatic logic [WAY_W-1:0] victim_inc(input logic [WAY_W-1:0] v);
    return (NR_WAYS > 1) ? v + WAY_W'(1) : {WAY_W{1'b0}};
  endfunction

  state_e              state_q, state_d;
  logic [RB-1:0]       cnt_q, cnt_d;
  logic                valid_q  [NR_ROWS][INSTR_PER_FETCH][NR_WAYS];
  logic                valid_d  [NR_ROWS][INSTR_PER_FETCH][NR_WAYS];
  logic [TAG_BITS-1:0] tag_q    [NR_ROWS][INSTR_PER_FETCH][NR_WAYS];
  logic [TAG_BITS-1:0] tag_d    [NR_ROWS][INSTR_PER_FETCH][NR_WAYS];
  logic [VLEN-1:0]     target_q [NR_ROWS][INSTR_PER_FETCH][NR_WAYS];
  logic [VLEN-1:0]     target_d [NR_ROWS][INSTR_PER_FETCH][NR_WAYS];
  logic [WAY_W-1:0]    victim_q [NR_ROWS][INSTR_PER_FETCH];
  logic [WAY_W-1:0]    victim_d [NR_ROWS][INSTR_PER_FETCH];

  logic [RB-1:0]                   lk_row_s;
  logic [TAG_BITS-1:0]             lk_tag_s;
  logic [INSTR_PER_FETCH-1:0]      hit_s;
  logic [INSTR_PER_FETCH*VLEN-1:0] tgt_s;

  logic [RB-1:0]       up_row_s;
  logic [SLOT_W-1:0]   up_slot_s;
  logic [TAG_BITS-1:0] up_tag_s;
  logic                accept_s;
  logic                up_hit_s;
  logic [WAY_W-1:0]    up_hit_way_s;
  logic                up_free_s;
  logic [WAY_W-1:0]    up_free_way_s;
  logic [WAY_W-1:0]    up_way_s;

  assign lk_row_s  = row_of(bus.vpc_i);
  assign lk_tag_s  = tag_of(bus.vpc_i);
  assign up_row_s  = row_of(bus.update_pc_i);
  assign up_slot_s = slot_of(bus.update_pc_i);
  assign up_tag_s  = tag_of(bus.update_pc_i);
  assign accept_s  = bus.update_valid_i && !bus.debug_mode_i && (state_q == IDLE) && !bus.flush_bp_i;

  // Lookup: descending scan so the lowest-index hitting way supplies the target.
  always_comb begin
    hit_s = '0;
    tgt_s = '0;
    for (int i = 0; i < int'(INSTR_PER_FETCH); i++) begin
      for (int w = int'(NR_WAYS) - 1; w >= 0; w--) begin
        hit_s[i] = hit_s[i] | (valid_q[lk_row_s][i][w] && (tag_q[lk_row_s][i][w] == lk_tag_s));
        tgt_s[i*VLEN +: VLEN] = (valid_q[lk_row_s][i][w] && (tag_q[lk_row_s][i][w] == lk_tag_s))
                                ? target_q[lk_row_s][i][w] : tgt_s[i*VLEN +: VLEN];
      end
    end
  end

  assign bus.pred_valid_o  = (state_q == SWEEP) ? {INSTR_PER_FETCH{1'b0}} : hit_s;
  assign bus.pred_target_o = tgt_s;
  assign bus.flush_busy_o  = (state_q == SWEEP);

  // Update-side way selection: existing tag first, then lowest free way, then victim.
  always_comb begin
    up_hit_s      = 1'b0;
    up_hit_way_s  = '0;
    up_free_s     = 1'b0;
    up_free_way_s = '0;
    for (int w = int'(NR_WAYS) - 1; w >= 0; w--) begin
      up_hit_s      = up_hit_s | (valid_q[up_row_s][up_slot_s][w] && (tag_q[up_row_s][up_slot_s][w] == up_tag_s));
      up_hit_way_s  = (valid_q[up_row_s][up_slot_s][w] && (tag_q[up_row_s][up_slot_s][w] == up_tag_s))
                      ? WAY_W'(w) : up_hit_way_s;
      up_free_s     = up_free_s | !valid_q[up_row_s][up_slot_s][w];
      up_free_way_s = !valid_q[up_row_s][up_slot_s][w] ? WAY_W'(w) : up_free_way_s;
    end
    up_way_s = up_free_s ? up_free_way_s : victim_q[up_row_s][up_slot_s];
  end

  // Next state: flush FSM plus table writes (updates are only accepted in IDLE).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    victim_d = victim_q;

    if (accept_s && up_hit_s) begin
      target_d[up_row_s][up_slot_s][up_hit_way_s] = bus.update_target_i;
    end else if (accept_s) begin
      valid_d[up_row_s][up_slot_s][up_way_s]  = 1'b1;
      tag_d[up_row_s][up_slot_s][up_way_s]    = up_tag_s;
      target_d[up_row_s][up_slot_s][up_way_s] = bus.update_target_i;
      victim_d[up_row_s][up_slot_s] = up_free_s ? victim_q[up_row_s][up_slot_s]
                                                : victim_inc(victim_q[up_row_s][up_slot_s]);
    end else begin
      victim_d = victim_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.flush_bp_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        for (int i = 0; i < int'(INSTR_PER_FETCH); i++) begin
          victim_d[cnt_q][i] = '0;
          for (int w = 0; w < int'(NR_WAYS); w++) begin
            valid_d[cnt_q][i][w] = 1'b0;
          end
        end
        if (bus.flush_bp_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else if (cnt_q == RB'(NR_ROWS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = SWEEP;
          cnt_d   = cnt_q + RB'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and valid/victim state; reset invalidates every entry at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int r = 0; r < int'(NR_ROWS); r++) begin
        for (int i = 0; i < int'(INSTR_PER_FETCH); i++) begin
          victim_q[r][i] <= '0;
          for (int w = 0; w < int'(NR_WAYS); w++) begin
            valid_q[r][i][w] <= 1'b0;
          end
        end
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      victim_q <= victim_d;
    end
  end

  // Tag/target payload carries no reset so it can map onto RAM.
  always_ff @(posedge clk_i) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (defaults: 2 slots, 16 rows, 2 ways, 8-bit tags):
// a vector table for lookup/update behaviour plus flush and reset sequences.
module tb_btb_assoc;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  btb_assoc_if #(.VLEN(64), .INSTR_PER_FETCH(2)) bif ();

  btb_assoc dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic        dbg;
    logic [63:0] upd_pc;
    logic [63:0] upd_tgt;
    logic [63:0] vpc;
    logic [1:0]  exp_valid;
    logic [63:0] exp_t0;
    logic [63:0] exp_t1;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [63:0] pc, input logic [63:0] tgt);
    bif.update_valid_i  = 1'b1;
    bif.update_pc_i     = pc;
    bif.update_target_i = tgt;
    step();
    bif.update_valid_i  = 1'b0;
  endtask

  task automatic fill_all();
    for (int r = 0; r < 16; r++) begin
      do_update(64'h2000 + 64'(r * 4), 64'h9000 + 64'(r));
      do_update(64'h2002 + 64'(r * 4), 64'hA000 + 64'(r));
    end
  endtask

  // Pulse flush, then count busy cycles, optionally re-pulsing or updating mid-sweep.
  task automatic run_flush(input int repulse_at, input int exp_busy, input bit upd_in_sweep,
                           input bit upd_with_flush);
    int busy_cnt;
    busy_cnt = 0;
    bif.vpc_i           = 64'h2000;
    bif.flush_bp_i      = 1'b1;
    bif.update_valid_i  = upd_with_flush;
    bif.update_pc_i     = 64'h1010;
    bif.update_target_i = 64'h5555;
    step();
    bif.flush_bp_i     = 1'b0;
    bif.update_valid_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!bif.flush_busy_o) break;
      busy_cnt++;
      chk("sweep pred_valid", 64'(bif.pred_valid_o), 64'd0);
      bif.flush_bp_i      = (busy_cnt == repulse_at);
      bif.update_valid_i  = upd_in_sweep && (busy_cnt == 3);
      bif.update_pc_i     = 64'h3000;
      bif.update_target_i = 64'h6666;
      step();
      bif.flush_bp_i     = 1'b0;
      bif.update_valid_i = 1'b0;
    end
    chk("busy length", 64'(busy_cnt), 64'(exp_busy));
  endtask

  task automatic lookup_chk(input string name, input logic [63:0] pc, input logic [1:0] exp_v);
    bif.vpc_i = pc;
    #1;
    chk(name, 64'(bif.pred_valid_o), 64'(exp_v));
  endtask

  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n               = 1'b0;
    bif.flush_bp_i      = 1'b0;
    bif.debug_mode_i    = 1'b0;
    bif.vpc_i           = 64'h0;
    bif.update_valid_i  = 1'b0;
    bif.update_pc_i     = 64'h0;
    bif.update_target_i = 64'h0;

    // Each vector: lookup result expected in the cycle the (optional) update is applied.
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1000, 2'b00, 64'h0,    64'h0});
    vecs.push_back('{1'b1, 1'b0, 64'h1000, 64'h2000, 64'h1000, 2'b00, 64'h0,    64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1000, 2'b01, 64'h2000, 64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1040, 2'b00, 64'h0,    64'h0});
    vecs.push_back('{1'b1, 1'b0, 64'h1002, 64'h2222, 64'h1000, 2'b01, 64'h2000, 64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1000, 2'b11, 64'h2000, 64'h2222});
    vecs.push_back('{1'b1, 1'b0, 64'h1040, 64'hB000, 64'h1040, 2'b00, 64'h0,    64'h0});
    vecs.push_back('{1'b1, 1'b0, 64'h1080, 64'hC000, 64'h1040, 2'b01, 64'hB000, 64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1000, 2'b10, 64'h0,    64'h2222});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1080, 2'b01, 64'hC000, 64'h0});
    vecs.push_back('{1'b1, 1'b0, 64'h10C0, 64'hD000, 64'h1040, 2'b01, 64'hB000, 64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1040, 2'b00, 64'h0,    64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h10C0, 2'b01, 64'hD000, 64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1080, 2'b01, 64'hC000, 64'h0});
    vecs.push_back('{1'b1, 1'b0, 64'h1004, 64'hA100, 64'h1004, 2'b00, 64'h0,    64'h0});
    vecs.push_back('{1'b1, 1'b0, 64'h1044, 64'hB100, 64'h1004, 2'b01, 64'hA100, 64'h0});
    vecs.push_back('{1'b1, 1'b0, 64'h1004, 64'h3000, 64'h1044, 2'b01, 64'hB100, 64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1004, 2'b01, 64'h3000, 64'h0});
    vecs.push_back('{1'b1, 1'b0, 64'h1084, 64'hC100, 64'h1084, 2'b00, 64'h0,    64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1004, 2'b00, 64'h0,    64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1044, 2'b01, 64'hB100, 64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1084, 2'b01, 64'hC100, 64'h0});
    vecs.push_back('{1'b1, 1'b1, 64'h1008, 64'hE000, 64'h1008, 2'b00, 64'h0,    64'h0});
    vecs.push_back('{1'b0, 1'b0, 64'h0,    64'h0,    64'h1008, 2'b00, 64'h0,    64'h0});

    repeat (2) step();
    chk("reset flush_busy", 64'(bif.flush_busy_o), 64'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      bif.update_valid_i  = vecs[i].upd;
      bif.debug_mode_i    = vecs[i].dbg;
      bif.update_pc_i     = vecs[i].upd_pc;
      bif.update_target_i = vecs[i].upd_tgt;
      bif.vpc_i           = vecs[i].vpc;
      #1;
      chk($sformatf("v%0d pred_valid", i), 64'(bif.pred_valid_o), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d target0", i), bif.pred_target_o[63:0], vecs[i].exp_t0);
      chk($sformatf("v%0d target1", i), bif.pred_target_o[127:64], vecs[i].exp_t1);
      chk($sformatf("v%0d flush_busy", i), 64'(bif.flush_busy_o), 64'd0);
      step();
    end
    bif.update_valid_i = 1'b0;
    bif.debug_mode_i   = 1'b0;

    // Full flush with an update attempted mid-sweep (row 0 already swept by then).
    fill_all();
    lookup_chk("filled row0", 64'h2000, 2'b11);
    lookup_chk("filled row15", 64'h203C, 2'b11);
    run_flush(0, 16, 1'b1, 1'b0);
    for (int r = 0; r < 16; r++) begin
      lookup_chk($sformatf("post-flush row%0d", r), 64'h2000 + 64'(r * 4), 2'b00);
    end
    lookup_chk("update in sweep dropped", 64'h3000, 2'b00);

    // Re-pulse at busy cycle 5, with an update issued alongside the first pulse.
    fill_all();
    run_flush(5, 21, 1'b0, 1'b1);
    lookup_chk("update with flush dropped", 64'h1010, 2'b00);
    lookup_chk("post-repulse row15", 64'h203C, 2'b00);

    // Asynchronous reset in the middle of a sweep.
    fill_all();
    bif.flush_bp_i = 1'b1;
    step();
    bif.flush_bp_i = 1'b0;
    repeat (3) step();
    #1;
    chk("busy before reset", 64'(bif.flush_busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("busy in reset", 64'(bif.flush_busy_o), 64'd0);
    lookup_chk("reset clears row15", 64'h203C, 2'b00);
    lookup_chk("reset clears row0", 64'h2000, 2'b00);
    #1;
    rst_n = 1'b1;
    step();
    chk("busy after reset", 64'(bif.flush_busy_o), 64'd0);
    lookup_chk("row15 after reset", 64'h203C, 2'b00);
    do_update(64'h1000, 64'h7000);
    lookup_chk("update after reset", 64'h1000, 2'b01);
    chk("target after reset", bif.pred_target_o[63:0], 64'h7000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
